// File: rtl/instr_loader.sv
// instr_loader: packs a host byte stream into 32-bit LE words and
// issues each with a one-cycle load strobe at consecutive addresses.
// Ports: sclk/reset (async, active-low); start, base_addr, word_count
// open a session; in_valid/in_data/in_ready is the byte channel;
// load/addr/instr drive the cores; busy, done, err report status.
// Option: define LOADER_CHECKSUM_EN to append a 4-byte XOR checksum
// after the last word and flag a mismatch on err.
module instr_loader #(
  parameter int ADDR_STEP = 4,
  parameter int COUNT_W   = 16
) (
  input  logic               sclk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               load,
  output logic [31:0]        addr,
  output logic [31:0]        instr,
  output logic               busy,
  output logic               done,
  output logic               err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, COLLECT, ISSUE, DONE, CHECK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, COLLECT, ISSUE, DONE
  } state_t;
`endif

  state_t             state;
  logic [1:0]         bidx;
  logic [COUNT_W-1:0] remaining;
  logic [31:0]        cur_addr;
  logic [31:0]        word;
  logic [31:0]        packed_w;
  logic               take;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0]        acc;
  logic               err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign take = in_valid & in_ready;

  // Partial word with the incoming byte dropped into lane bidx.
  always_comb begin
    packed_w = word;
    packed_w[{bidx, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bidx      <= 2'd0;
      remaining <= '0;
      cur_addr  <= 32'd0;
      word      <= 32'd0;
      in_ready  <= 1'b0;
      load      <= 1'b0;
      addr      <= 32'd0;
      instr     <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc       <= 32'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              cur_addr  <= base_addr;
              remaining <= word_count;
              bidx      <= 2'd0;
              word      <= 32'd0;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              state     <= COLLECT;
`ifdef LOADER_CHECKSUM_EN
              acc       <= 32'd0;
              err_q     <= 1'b0;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (take) begin
            word <= packed_w;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              in_ready <= 1'b0;
              load     <= 1'b1;
              addr     <= cur_addr;
              instr    <= packed_w;
              state    <= ISSUE;
`ifdef LOADER_CHECKSUM_EN
              acc      <= acc ^ packed_w;
`endif
            end
          end
        end
        ISSUE: begin
          cur_addr  <= cur_addr + 32'(ADDR_STEP);
          remaining <= remaining - COUNT_W'(1);
          if (remaining == COUNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            in_ready <= 1'b1;
            state    <= CHECK;
`else
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
`endif
          end else begin
            in_ready <= 1'b1;
            state    <= COLLECT;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          // Trailing checksum word is compared, never issued.
          if (take) begin
            word <= packed_w;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              err_q    <= (packed_w != acc);
              state    <= DONE;
            end
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: random and directed sessions against an
// event-level model of the byte packer and load sequencer.
module tb_instr_loader;

  logic        sclk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        load;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        busy;
  logic        done;
  logic        err;

  instr_loader #(.ADDR_STEP(4), .COUNT_W(16)) dut (
    .sclk(sclk), .reset(reset), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load(load), .addr(addr),
    .instr(instr), .busy(busy), .done(done), .err(err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs for the current cycle.
  bit          e_load, e_done, e_ready, e_busy, e_err;
  logic [31:0] e_addr, e_instr;
  // Session bookkeeping.
  bit          m_active, m_chk, m_done_cyc;
  int          m_left;
  logic [31:0] m_addr, m_acc, m_w;
  logic [7:0]  m_bytes[$];
  bit          was_load, was_ready, was_done_cyc;
  // Observed history.
  logic [31:0] la_q[$];
  logic [31:0] li_q[$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_load_cyc = 0;
  int          last_done_cyc = 0;

  always @(negedge sclk) begin
    cyc++;
    if (!reset) begin
      chk("rst_load", load, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", addr, 0);
      chk("rst_instr", instr, 0);
      e_load = 0; e_done = 0; e_ready = 0;
      e_busy = 0; e_err = 0;
      e_addr = 0; e_instr = 0;
      m_active = 0; m_chk = 0; m_done_cyc = 0;
      m_bytes.delete();
    end else begin
      chk("load", load, e_load);
      chk("in_ready", in_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("addr", addr, e_addr);
      chk("instr", instr, e_instr);
      if (load) begin
        la_q.push_back(addr);
        li_q.push_back(instr);
        last_load_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      // Advance the model to next cycle's outputs.
      was_load = e_load;
      was_ready = e_ready;
      was_done_cyc = m_done_cyc;
      e_load = 0;
      e_done = 0;
      m_done_cyc = 0;
      if (was_load) begin
        m_addr = m_addr + 32'd4;
        m_left--;
        if (m_left == 0) begin
`ifdef LOADER_CHECKSUM_EN
          m_chk = 1;
          e_ready = 1;
`else
          e_done = 1;
          e_busy = 0;
          m_active = 0;
          m_done_cyc = 1;
`endif
        end else begin
          e_ready = 1;
        end
      end else if (m_active && was_ready && in_valid) begin
        m_bytes.push_back(in_data);
        if (m_bytes.size() == 4) begin
          m_w = {m_bytes[3], m_bytes[2],
                 m_bytes[1], m_bytes[0]};
          m_bytes.delete();
          e_ready = 0;
          if (m_chk) begin
            e_done = 1;
            e_busy = 0;
            e_err = (m_w != m_acc);
            m_active = 0;
            m_chk = 0;
            m_done_cyc = 1;
          end else begin
            e_load = 1;
            e_addr = m_addr;
            e_instr = m_w;
            m_acc = m_acc ^ m_w;
          end
        end
      end else if (!m_active && !was_done_cyc && start) begin
        if (word_count != 0) begin
          m_active = 1;
          e_busy = 1;
          e_ready = 1;
          m_addr = base_addr;
          m_left = int'(word_count);
          m_acc = 0;
          e_err = 0;
        end else begin
          e_done = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap,
                           input bit noise);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin
      start = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      word_count = 16'($urandom);
      base_addr = $urandom;
      tick();
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (t = 0; t < 100; t++) begin
      @(negedge sclk);
      if (in_ready) break;
    end
    if (t == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_timeout: in_ready low 100 cycles");
    end
    @(posedge sclk);
    #2;
    in_valid = 1'b0;
    in_data = $urandom;
  endtask

  task automatic session(input logic [31:0] base,
                         input int cnt,
                         input logic [7:0] bq[$],
                         input int maxgap,
                         input bit noise);
    int t;
    start = 1'b1;
    base_addr = base;
    word_count = 16'(cnt);
    tick();
    start = 1'b0;
    base_addr = $urandom;
    word_count = 16'($urandom);
    foreach (bq[i])
      send_byte(bq[i], $urandom_range(0, maxgap), noise);
    start = 1'b0;
    for (t = 0; t < 100; t++) begin
      @(negedge sclk);
      if (done) break;
    end
    if (t == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done pulse");
    end
    tick();
  endtask

  logic [7:0] bq[$];
  int         lc;
  int         dc;
  int         n;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = 0;
    word_count = 0;
    in_valid = 1'b0;
    in_data = 0;
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Directed: two words back to back.
    la_q.delete(); li_q.delete();
    bq = '{8'h01, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h08};
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(8'h04); bq.push_back(8'h04);
    bq.push_back(8'h04); bq.push_back(8'h0C);
`endif
    session(32'h100, 2, bq, 0, 0);
    chk("t1_nloads", la_q.size(), 2);
    chk("t1_a0", la_q[0], 32'h100);
    chk("t1_i0", li_q[0], 32'h04030201);
    chk("t1_a1", la_q[1], 32'h104);
    chk("t1_i1", li_q[1], 32'h08070605);
`ifndef LOADER_CHECKSUM_EN
    chk("t1_done_lat", last_done_cyc - last_load_cyc, 1);
`endif

    // Same words with random stalls.
    la_q.delete(); li_q.delete();
    session(32'h100, 2, bq, 7, 1);
    chk("t2_nloads", la_q.size(), 2);
    chk("t2_i0", li_q[0], 32'h04030201);
    chk("t2_i1", li_q[1], 32'h08070605);
    chk("t2_a1", la_q[1], 32'h104);

    // Zero-length session.
    lc = la_q.size();
    dc = done_cnt;
    bq.delete();
    session(32'h40, 0, bq, 0, 0);
    chk("t3_noload", la_q.size(), lc);
    chk("t3_done", done_cnt, dc + 1);

    // Reset in the middle of word 0.
    start = 1'b1;
    base_addr = 32'h300;
    word_count = 16'd3;
    tick();
    start = 1'b0;
    send_byte(8'h99, 0, 0);
    send_byte(8'h98, 0, 0);
    reset = 1'b0;
    #1;
    chk("t4_ready", in_ready, 0);
    chk("t4_busy", busy, 0);
    chk("t4_load", load, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    la_q.delete(); li_q.delete();
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(8'hAA); bq.push_back(8'hBB);
    bq.push_back(8'hCC); bq.push_back(8'hDD);
`endif
    session(32'h200, 1, bq, 2, 0);
    chk("t4_nloads", la_q.size(), 1);
    chk("t4_a0", la_q[0], 32'h200);
    chk("t4_i0", li_q[0], 32'hDDCCBBAA);

    // Address wrap.
    la_q.delete(); li_q.delete();
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
`endif
    session(32'hFFFF_FFFC, 2, bq, 3, 1);
    chk("t5_a0", la_q[0], 32'hFFFF_FFFC);
    chk("t5_a1", la_q[1], 32'h0000_0000);

`ifdef LOADER_CHECKSUM_EN
    bq = '{8'h11, 8'h11, 8'h11, 8'h11,
           8'h22, 8'h22, 8'h22, 8'h22,
           8'h33, 8'h33, 8'h33, 8'h33};
    session(32'h0, 2, bq, 1, 0);
    chk("t6_err0", err, 0);
    bq = '{8'h11, 8'h11, 8'h11, 8'h11,
           8'h22, 8'h22, 8'h22, 8'h22,
           8'h34, 8'h33, 8'h33, 8'h33};
    session(32'h0, 2, bq, 1, 0);
    chk("t6_err1", err, 1);
    start = 1'b1;
    base_addr = 32'h80;
    word_count = 16'd1;
    tick();
    start = 1'b0;
    #1;
    chk("t6_errclr", err, 0);
    bq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5,
           8'hA5, 8'hA5, 8'hA5, 8'hA5};
    foreach (bq[i]) send_byte(bq[i], 0, 0);
    repeat (4) tick();
    chk("t6_err_ok", err, 0);
`endif

    // Random sessions.
    for (int s = 0; s < 25; s++) begin
      n = $urandom_range(0, 4);
      bq.delete();
      if (n != 0) begin
        for (int i = 0; i < 4 * n; i++)
          bq.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        for (int i = 0; i < 4; i++)
          bq.push_back(8'($urandom));
`endif
      end
      session((s % 3 == 0) ? 32'hFFFF_FFF0 : $urandom,
              n, bq, 7, 1);
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
